// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto one UART transmitter.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module uart_tx_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             tx_busy,
  output logic             tx_data_valid,
  output logic [DW-1:0]    tx_p_data,
  output logic [1:0]       grant_id,
  output logic             grant_active,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic          grant_active_q, grant_active_d;
  logic          tx_data_valid_q, tx_data_valid_d;
  logic [DW-1:0] tx_p_data_q, tx_p_data_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic [1:0]    win;
  logic          found;
  logic          accept;

  // Search upward from ptr; with ptr pinned at 0 this is lowest-index-wins.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[ptr_q + 2'(k)]) begin
        win   = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && !tx_busy && found;

  always_comb begin
    req_ready = '0;
    if (accept && rst)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_id_d      = grant_id_q;
    grant_active_d  = grant_active_q;
    tx_data_valid_d = 1'b0;
    tx_p_data_d     = tx_p_data_q;
    frame_cnt_d     = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d         = LAUNCH;
          grant_id_d      = win;
          grant_active_d  = 1'b1;
          tx_data_valid_d = 1'b1;
          tx_p_data_d     = req_data[int'(win)*DW +: DW];
`ifndef UART_ARB_FIXED_PRIO_EN
          ptr_d           = win + 2'd1;
`endif
        end
      end
      LAUNCH: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)
          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d        = IDLE;
          grant_active_d = 1'b0;
          frame_cnt_d    = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      grant_id_q      <= '0;
      grant_active_q  <= 1'b0;
      tx_data_valid_q <= 1'b0;
      tx_p_data_q     <= '0;
      frame_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_id_q      <= grant_id_d;
      grant_active_q  <= grant_active_d;
      tx_data_valid_q <= tx_data_valid_d;
      tx_p_data_q     <= tx_p_data_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign grant_id      = grant_id_q;
  assign grant_active  = grant_active_q;
  assign tx_data_valid = tx_data_valid_q;
  assign tx_p_data     = tx_p_data_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
Parameters:
REQ-001 NREQ, 4, number of byte requesters sharing one UART transmitter; fixed at 4, so the grant index is 2 bits.
REQ-002 DW, 8, byte width per requester.

Ports:
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester byte-available flag.
REQ-006 req_data  in  NREQ*DW  packed bytes; requester i occupies bits [8i+7:8i].
REQ-007 req_ready  out  NREQ  per-requester accept strobe; byte i transfers when req_valid[i] and req_ready[i] are both high on a clock edge.
REQ-008 tx_busy  in  1  busy flag from the UART transmitter.
REQ-009 tx_data_valid  out  1  one-cycle launch strobe to the UART transmitter.
REQ-010 tx_p_data  out  DW  byte presented to the UART transmitter.
REQ-011 grant_id  out  2  index of the requester currently owning the transmitter.
REQ-012 grant_active  out  1  high from acceptance until frame completion.
REQ-013 frame_cnt  out  16  count of completed frames.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE; reset state is IDLE.
REQ-015 IDLE:
- If tx_busy=0 and any req_valid is high, select winner g and drive req_ready[g]=1 combinationally.
- On that edge: latch req_data[g] into the data register, latch g into grant_id, go to LAUNCH.
- Otherwise stay in IDLE with req_ready=0.
REQ-016 req_ready: at most one bit high in any cycle; all bits are 0 outside IDLE and whenever tx_busy=1.
REQ-017 Round-robin selection: search upward from pointer ptr, modulo 4; on acceptance of g, ptr <= (g+1) mod 4.
REQ-018 LAUNCH: assert tx_data_valid=1 for exactly one cycle with tx_p_data = latched byte, then go to WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
REQ-020 WAIT_DONE: stay while tx_busy=1; when tx_busy=0, go to IDLE and set frame_cnt <= frame_cnt+1.
REQ-021 frame_cnt wraps from 0xFFFF to 0x0000.
REQ-022 tx_p_data holds the latched byte from LAUNCH through WAIT_DONE; it holds its last value in IDLE.
REQ-023 grant_active=1 in LAUNCH, WAIT_BUSY and WAIT_DONE; 0 in IDLE.
REQ-024 Acceptance latency: byte accepted in cycle n gives tx_data_valid=1 in cycle n+1.
- Back-to-back frames: the next acceptance occurs no earlier than the cycle after the return to IDLE.
REQ-025 req_valid dropped before acceptance: no transfer and no state change.
- Requests arriving during WAIT_* are not accepted until IDLE.
REQ-026 tx_busy=1 while in IDLE (external activity): no acceptance until tx_busy=0.

Reset
REQ-027 rst low asynchronously forces all of the following, at any point including mid-frame:
- state=IDLE, ptr=0, grant_id=0, grant_active=0;
- tx_data_valid=0, tx_p_data=0x00, frame_cnt=0, req_ready=0.
REQ-028 A frame interrupted by reset is not counted and not relaunched.

Configuration
REQ-029 Macro UART_ARB_FIXED_PRIO_EN selects the arbitration scheme:
- Defined: fixed priority; lowest asserted index wins; ptr stays 0.
- Undefined: round-robin per REQ-017.
- All other behaviour is identical in both builds.

Verification
REQ-030 Single request: req_valid=0001, data 0x5A, idle transmitter -> req_ready=0001 for 1 cycle; tx_data_valid 1 cycle later with tx_p_data=0x5A; frame_cnt=1 after tx_busy falls.
REQ-031 All four requesters held valid, distinct bytes 0x10/0x21/0x32/0x43 -> round-robin build grants 0,1,2,3,0; fixed-priority build grants 0,0,0.
REQ-032 tx_busy held high in IDLE with req_valid=0100 -> req_ready stays 0000; accept occurs in the first cycle after tx_busy=0.
REQ-033 rst pulsed low during WAIT_DONE -> all outputs take reset values immediately; frame_cnt=0; no relaunch after release.
REQ-034 frame_cnt preloaded by 65535 completed frames, one more frame -> frame_cnt=0x0000.
REQ-035 req_valid=0010 dropped in the same cycle a frame completes -> no acceptance; ptr unchanged.
